alu_exec_stage: RTL and testbench

//   Execute stage of the 8-bit accumulator CPU, directly downstream of the register file.

---
 rtl/alu_exec_stage.sv | 148 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
//==============================================================================
// Module      : alu_exec_stage
// Description : Execute stage of the 8-bit accumulator CPU. Runs single-cycle
//               ALU ops or shift-add MUL and returns a one-cycle writeback.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_exec_stage #(
    parameter logic [2:0] ACC_ADDR  = 3'd7,
    parameter int         MUL_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [2:0] op_dest,
    input  logic [7:0] reg_acc_in,
    input  logic [7:0] reg_b_in,
    output logic [7:0] wb_data,
    output logic [2:0] wb_addr,
    output logic       wb_en,
    output logic       flag_z,
    output logic       flag_c,
    output logic       busy
);

    localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MUL_STEPS - 1);
    localparam logic [2:0] c_OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_code;
    logic [2:0]       r_dest;
    logic [7:0]       r_acc;
    logic [7:0]       r_b;
    logic [15:0]      r_mcand;
    logic [7:0]       r_mplier;
    logic [15:0]      r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_wb_data;
    logic [2:0]       r_wb_addr;
    logic             r_wb_en;
    logic             r_flag_z;
    logic             r_flag_c;

    logic [8:0]       w_res9;
    logic [15:0]      w_prod_next;

    // Bit 8 of the 9-bit result is the carry/borrow/shifted-out bit.
    always_comb begin
        w_res9 = 9'd0;
        case (r_code)
            3'b000:  w_res9 = {1'b0, r_acc} + {1'b0, r_b};
            3'b001:  w_res9 = {1'b0, r_acc} - {1'b0, r_b};
            3'b010:  w_res9 = {1'b0, r_acc & r_b};
            3'b011:  w_res9 = {1'b0, r_acc | r_b};
            3'b100:  w_res9 = {1'b0, r_acc ^ r_b};
            3'b101:  w_res9 = {1'b0, r_acc} << r_b[2:0];
            3'b111:  w_res9 = {1'b0, r_b};
            default: w_res9 = 9'd0;
        endcase
    end

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_code    <= 3'd0;
            r_dest    <= ACC_ADDR;
            r_acc     <= 8'd0;
            r_b       <= 8'd0;
            r_mcand   <= 16'd0;
            r_mplier  <= 8'd0;
            r_prod    <= 16'd0;
            r_cnt     <= '0;
            r_wb_data <= 8'd0;
            r_wb_addr <= 3'd0;
            r_wb_en   <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
        end else begin
            r_wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_code   <= op_code;
                        r_dest   <= op_dest;
                        r_acc    <= reg_acc_in;
                        r_b      <= reg_b_in;
                        r_mcand  <= {8'd0, reg_acc_in};
                        r_mplier <= reg_b_in;
                        r_prod   <= 16'd0;
                        r_cnt    <= '0;
                        r_state  <= (op_code == c_OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_wb_data <= w_res9[7:0];
                    r_wb_addr <= r_dest;
                    r_wb_en   <= 1'b1;
                    r_flag_z  <= (w_res9[7:0] == 8'd0);
                    r_flag_c  <= w_res9[8];
                    r_state   <= S_WB;
                end
                S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // Final iteration: publish the product that is being formed now.
                    if (r_cnt == c_CNT_LAST) begin
                        r_wb_data <= w_prod_next[7:0];
                        r_wb_addr <= r_dest;
                        r_wb_en   <= 1'b1;
                        r_flag_z  <= (w_prod_next[7:0] == 8'd0);
                        r_flag_c  <= |w_prod_next[15:8];
                        r_state   <= S_WB;
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_ready = (r_state == S_IDLE);
    assign busy     = ~op_ready;
    assign wb_data  = r_wb_data;
    assign wb_addr  = r_wb_addr;
    assign wb_en    = r_wb_en;
    assign flag_z   = r_flag_z;
    assign flag_c   = r_flag_c;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
//==============================================================================
// Module      : tb_alu_exec_stage
// Description : Self-checking bench for alu_exec_stage: directed cases plus
//               randomized ops against an arithmetic reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_exec_stage;

    logic       clk;
    logic       reset;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [2:0] op_dest;
    logic [7:0] reg_acc_in;
    logic [7:0] reg_b_in;
    logic [7:0] wb_data;
    logic [2:0] wb_addr;
    logic       wb_en;
    logic       flag_z;
    logic       flag_c;
    logic       busy;

    logic [7:0] acc_drv;
    logic       loop_mode;
    logic [7:0] rf [8];

    int n_cmp;
    int n_err;
    logic exp_z;
    logic exp_c;

    alu_exec_stage #(.ACC_ADDR(3'd7), .MUL_STEPS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_dest    (op_dest),
        .reg_acc_in (reg_acc_in),
        .reg_b_in   (reg_b_in),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .wb_en      (wb_en),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file in the loop: writes on the edge where wb_en is high.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

    assign reg_acc_in = loop_mode ? rf[7] : acc_drv;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result {carry, result} from plain integer arithmetic.
    function automatic logic [8:0] ref_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        int t;
        int sh;
        logic cy;
        t  = 0;
        cy = 1'b0;
        case (c)
            3'd0: begin t = int'(a) + int'(b); cy = (t > 255); end
            3'd1: begin t = int'(a) - int'(b) + 256; cy = (a < b); end
            3'd2: t = int'(a & b);
            3'd3: t = int'(a | b);
            3'd4: t = int'(a ^ b);
            3'd5: begin
                sh = int'(b) % 8;
                t  = int'(a) * (1 << sh);
                cy = (sh != 0) && (((int'(a) >> (8 - sh)) & 1) == 1);
            end
            3'd6: begin t = int'(a) * int'(b); cy = (t > 255); end
            default: t = int'(b);
        endcase
        return {cy, 8'(t % 256)};
    endfunction

    task automatic do_op(input logic [2:0] code, input logic [2:0] dest,
                         input logic [7:0] a, input logic [7:0] b);
        int n;
        int lat;
        logic [8:0] e;
        n = 0;
        while (!op_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_op", 16'(op_ready), 16'd1);
        op_valid = 1'b1; op_code = code; op_dest = dest; acc_drv = a; reg_b_in = b;
        @(posedge clk); #1;
        // Scramble inputs after accept; only latched operands may be used.
        op_valid = 1'b0;
        op_code  = 3'($urandom);
        op_dest  = 3'($urandom);
        acc_drv  = 8'($urandom);
        reg_b_in = 8'($urandom);
        e   = ref_op(code, a, b);
        lat = (code == 3'd6) ? 8 : 1;
        n   = 0;
        while (!wb_en && n < 20) begin
            check("ready_low_busy", 16'(op_ready), 16'd0);
            check("flags_hold", 16'({flag_z, flag_c}), 16'({exp_z, exp_c}));
            @(posedge clk); #1; n++;
        end
        check("wb_latency", 16'(n), 16'(lat));
        check("wb_data", 16'(wb_data), 16'(e[7:0]));
        check("wb_addr", 16'(wb_addr), 16'(dest));
        check("flag_z", 16'(flag_z), 16'(e[7:0] == 8'd0));
        check("flag_c", 16'(flag_c), 16'(e[8]));
        check("busy_at_wb", 16'(busy), 16'd1);
        exp_z = (e[7:0] == 8'd0);
        exp_c = e[8];
        @(posedge clk); #1;
        check("wb_en_drop", 16'(wb_en), 16'd0);
        check("ready_after_wb", 16'(op_ready), 16'd1);
        check("wb_data_hold", 16'(wb_data), 16'(e[7:0]));
        check("wb_addr_hold", 16'(wb_addr), 16'(dest));
    endtask

    initial begin
        int pulses;
        n_cmp = 0; n_err = 0;
        exp_z = 1'b0; exp_c = 1'b0;
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_dest = 3'd0;
        acc_drv = 8'd0; reg_b_in = 8'd0; loop_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_wb_data", 16'(wb_data), 16'd0);
        check("rst_wb_addr", 16'(wb_addr), 16'd0);
        check("rst_wb_en", 16'(wb_en), 16'd0);
        check("rst_flags", 16'({flag_z, flag_c}), 16'd0);
        check("rst_ready", 16'(op_ready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);

        do_op(3'd0, 3'd7, 8'hF0, 8'h20);
        do_op(3'd1, 3'd7, 8'h05, 8'h05);
        do_op(3'd1, 3'd7, 8'h03, 8'h05);
        do_op(3'd6, 3'd7, 8'h0D, 8'h13);
        do_op(3'd6, 3'd7, 8'h10, 8'h10);
        do_op(3'd5, 3'd7, 8'h81, 8'h01);
        do_op(3'd5, 3'd7, 8'h81, 8'h00);
        do_op(3'd7, 3'd7, 8'h55, 8'h00);
        do_op(3'd0, 3'd7, 8'hFF, 8'h02);

        // Reset during MUL iteration 4 must abort with no writeback.
        op_valid = 1'b1; op_code = 3'd6; op_dest = 3'd7; acc_drv = 8'h0D; reg_b_in = 8'h13;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("abort_wb_data", 16'(wb_data), 16'd0);
        check("abort_flags", 16'({flag_z, flag_c}), 16'd0);
        check("abort_ready", 16'(op_ready), 16'd1);
        exp_z = 1'b0; exp_c = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (wb_en) pulses++;
            @(posedge clk); #1;
        end
        check("abort_no_wb_en", 16'(pulses), 16'd0);

        // Held request with register file in the loop: r7 += 3, four times.
        loop_mode = 1'b1;
        op_valid = 1'b1; op_code = 3'd0; op_dest = 3'd7; reg_b_in = 8'h03;
        pulses = 0;
        for (int i = 0; i < 60 && pulses < 4; i++) begin
            @(posedge clk); #1;
            if (wb_en) pulses++;
        end
        op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_en) pulses++;
        end
        check("loop_pulses", 16'(pulses), 16'd4);
        check("loop_r7", 16'(rf[7]), 16'h0C);
        check("loop_wb_data", 16'(wb_data), 16'h0C);
        exp_z = 1'b0; exp_c = 1'b0;
        loop_mode = 1'b0;

        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
